// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for the architectural register file: write port, three read ports,
// PC+8 input and the busy scoreboard set/query signals.
interface regfile_scoreboard_if #(
    parameter int unsigned WIDTH = 32
);
    logic             we3;
    logic [3:0]       wa3;
    logic [WIDTH-1:0] wd3;
    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [3:0]       ra3;
    logic [WIDTH-1:0] r15;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] rd3;
    logic             set_busy;
    logic [3:0]       set_addr;
    logic             busy1;
    logic             busy2;
    logic             busy3;
    logic [14:0]      busy_vec;

    modport master (
        output we3, wa3, wd3, ra1, ra2, ra3, r15, set_busy, set_addr,
        input  rd1, rd2, rd3, busy1, busy2, busy3, busy_vec
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, ra3, r15, set_busy, set_addr,
        output rd1, rd2, rd3, busy1, busy2, busy3, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// R0..R14 register file with three combinational read ports, one write port,
// R15 reads returning PC+8, and a per-register busy scoreboard for stalls.
module regfile_scoreboard #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    regfile_scoreboard_if.slave  bus
);
    logic [14:0][WIDTH-1:0] regs_q;
    logic [14:0]            busy_q;
    logic [14:0]            busy_d;
    logic [14:0]            wr_en;

    logic [2:0][3:0]        ra;
    logic [2:0][WIDTH-1:0]  rd;
    logic [2:0]             rbusy;

    // Index 15 never matches any entry, so writes and sets to R15 fall away here.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            wr_en[i]  = bus.we3 && (bus.wa3 == 4'(i));
            busy_d[i] = busy_q[i];
            if (bus.set_busy && (bus.set_addr == 4'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en[i]) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (wr_en[i]) begin
                    regs_q[i] <= bus.wd3;
                end
            end
            busy_q <= busy_d;
        end
    end

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;
    assign ra[2] = bus.ra3;

    // Busy flags come from registered state only; a same-cycle clear is not forwarded.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd[p]    = '0;
            rbusy[p] = 1'b0;
            for (int i = 0; i < 15; i++) begin
                if (ra[p] == 4'(i)) begin
                    rd[p]    = regs_q[i];
                    rbusy[p] = busy_q[i];
                end
            end
            if (ra[p] == 4'd15) begin
                rd[p] = bus.r15;
            end else if (BYPASS && bus.we3 && (bus.wa3 == ra[p])) begin
                rd[p] = bus.wd3;
            end
        end
    end

    assign bus.rd1      = rd[0];
    assign bus.rd2      = rd[1];
    assign bus.rd3      = rd[2];
    assign bus.busy1    = rbusy[0];
    assign bus.busy2    = rbusy[1];
    assign bus.busy3    = rbusy[2];
    assign bus.busy_vec = busy_q;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural register file for the ARM datapath. It is the direct downstream consumer of the writeback result mux: the mux output drives wd3.
- Holds R0–R14. Provides three combinational read ports (Rn, Rm, Rs/Rd-for-STR) and one synchronous write port.
- Reads of R15 return the externally supplied PC+8.
- Carries a per-register busy scoreboard so the controller can stall on outstanding multicycle producers (loads, multiplies).

Parameters:
- WIDTH, 32, data width of each register and of every data port.
- BYPASS, 1, 1 = write-first forwarding of wd3 to same-cycle reads; 0 = reads return the pre-write value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- we3  input  1  write enable for the write port.
- wa3  input  4  write address.
- wd3  input  WIDTH  write data (from the result mux).
- ra1  input  4  read address, port 1.
- ra2  input  4  read address, port 2.
- ra3  input  4  read address, port 3.
- r15  input  WIDTH  PC+8 value returned for reads of address 15.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- rd3  output  WIDTH  read data, port 3.
- set_busy  input  1  marks register set_addr as having an outstanding producer.
- set_addr  input  4  register to mark busy.
- busy1  output  1  busy flag of ra1.
- busy2  output  1  busy flag of ra2.
- busy3  output  1  busy flag of ra3.
- busy_vec  output  15  busy flags for R0..R14, bit i = Ri.

Behaviour:
- Storage:
  - 15 × WIDTH registers, R0..R14.
  - 15-bit busy register.
  - No storage for R15.
- Reset (synchronous, reset high at a rising edge):
  - All R0..R14 become 0; busy_vec becomes 0.
  - Reset has priority over we3 and set_busy in the same cycle.
  - A reset asserted mid-operation discards any in-flight write or set on that edge.
- After reset:
  - rdN = 0 for raN != 15.
  - rdN = r15 for raN == 15.
  - All busyN = 0.
- Write:
  - On a rising edge with we3=1 and wa3 != 15: R[wa3] <= wd3.
  - wa3 == 15 is ignored; no register changes. The PC is written by the fetch stage, not here.
- Read (combinational, zero latency):
  - raN == 15 -> rdN = r15.
  - BYPASS=1 and we3=1 and wa3 == raN and wa3 != 15 -> rdN = wd3.
  - Otherwise rdN = R[raN].
  - BYPASS=0 -> the new value is visible only after the edge.
  - All three ports are independent. Any combination of equal addresses is legal and returns identical data.
- Scoreboard (per register i in 0..14, evaluated at each rising edge):
  - set_busy=1 and set_addr == i -> busy[i] <= 1.
  - Else if we3=1 and wa3 == i -> busy[i] <= 0. This is the writeback completing.
  - Else busy[i] holds.
- Scoreboard conflicts and limits:
  - Simultaneous set and clear of the same register: set wins. A new producer was issued in the same cycle the old one retired.
  - set_addr == 15 is ignored.
  - Setting an already-busy register keeps it busy; there is no count of multiple producers.
  - A write to a non-busy register is legal and leaves it non-busy.
- busyN outputs:
  - busyN = busy[raN] for raN != 15; busyN = 0 for raN == 15.
  - busyN reflects registered state only. The same-cycle clear is not forwarded to busyN, even with BYPASS=1. The controller sees the clear one cycle later.
- Widths:
  - No arithmetic is performed. wd3 and r15 pass through unmodified at WIDTH bits.
  - Addresses are 4 bits with no out-of-range values.

Test Plan:
- Reset and R15 read:
  - Stimulus: assert reset with we3=1, wa3=3, wd3=0xDEADBEEF, set_busy=1, set_addr=3. Release reset. Drive ra1=3, ra2=15, r15=0x00000108.
  - Required: rd1=0, rd2=0x00000108, busy1=0, busy_vec=0.
- Write and readback on all ports:
  - Stimulus: write R5=0x12345678, then R14=0xFFFFFFFF. Drive ra1=5, ra2=14, ra3=5.
  - Required: rd1=0x12345678, rd2=0xFFFFFFFF, rd3=0x12345678.
- R15 write is ignored:
  - Stimulus: we3=1, wa3=15, wd3=0xAAAAAAAA, then read ra1=15 with r15=0x20.
  - Required: rd1=0x20; busy_vec and all of R0..R14 unchanged.
- Bypass with BYPASS=1:
  - Stimulus: R2=0x11. In one cycle drive we3=1, wa3=2, wd3=0x22, ra1=2.
  - Required: rd1=0x22 before the edge and 0x22 after.
  - Same stimulus with BYPASS=0: rd1=0x11 before the edge, 0x22 after.
- Scoreboard set and clear:
  - Stimulus: set_busy on R7, hold ra1=7, then write R7 two cycles later.
  - Required: busy1=1 from the cycle after the set until the edge of the write; busy1=0 the cycle after the write; busy_vec bit 7 follows the same timing.
- Scoreboard set/clear conflict:
  - Stimulus: R4 busy. In one cycle drive set_busy=1, set_addr=4, we3=1, wa3=4, wd3=0x99.
  - Required: R4=0x99 and busy_vec bit 4 stays 1.
  - A following cycle with we3=1, wa3=4 clears bit 4 to 0.
